// File: rtl/mixer_pwm.sv
// Three-channel tone/noise mixer feeding a 2^PWM_BITS-cycle PWM DAC.
// Levels are registered, then summed, then latched once per period as the duty value.
module mixer_pwm #(
  parameter int PWM_BITS = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tone_a,
  input  logic       tone_b,
  input  logic       tone_c,
  input  logic       noise,
  input  logic [5:0] mixer,
  input  logic [4:0] amp_a,
  input  logic [4:0] amp_b,
  input  logic [4:0] amp_c,
  input  logic [3:0] envelope,
  output logic       pwm_out,
  output logic       sample_strobe
);

  localparam logic [PWM_BITS-1:0] CNT_MAX = '1;

  // A channel is silent unless both its tone and noise paths are open.
  function automatic logic [3:0] chan_level(
    input logic       tone,
    input logic       tone_dis,
    input logic       noise_in,
    input logic       noise_dis,
    input logic [4:0] amp,
    input logic [3:0] env
  );
    logic gate;
    gate = (tone | tone_dis) & (noise_in | noise_dis);
    if (!gate) return 4'd0;
    return amp[4] ? env : amp[3:0];
  endfunction

  function automatic logic [PWM_BITS-1:0] widen_sum(input logic [5:0] s);
    return PWM_BITS'(s);
  endfunction

  logic [3:0]          level_a_p1_d, level_a_p1_q;
  logic [3:0]          level_b_p1_d, level_b_p1_q;
  logic [3:0]          level_c_p1_d, level_c_p1_q;
  logic [5:0]          sum_p2_d, sum_p2_q;
  logic [PWM_BITS-1:0] cnt_d, cnt_q;
  logic [PWM_BITS-1:0] sample_d, sample_q;
  logic                pwm_d, pwm_q;
  logic                strobe_d, strobe_q;

  always_comb begin
    // stage 1: per-channel gated levels
    level_a_p1_d = chan_level(tone_a, mixer[0], noise, mixer[3], amp_a, envelope);
    level_b_p1_d = chan_level(tone_b, mixer[1], noise, mixer[4], amp_b, envelope);
    level_c_p1_d = chan_level(tone_c, mixer[2], noise, mixer[5], amp_c, envelope);
    // stage 2: mix (max 45, fits in 6 bits)
    sum_p2_d = {2'b00, level_a_p1_q} + {2'b00, level_b_p1_q} + {2'b00, level_c_p1_q};
    // PWM: duty value only changes on the wrap edge
    cnt_d    = cnt_q + 1'b1;
    sample_d = (cnt_q == CNT_MAX) ? widen_sum(sum_p2_q) : sample_q;
    pwm_d    = (cnt_q < sample_q);
    strobe_d = (cnt_q == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      level_a_p1_q <= '0;
      level_b_p1_q <= '0;
      level_c_p1_q <= '0;
      sum_p2_q     <= '0;
      cnt_q        <= '0;
      sample_q     <= '0;
      pwm_q        <= 1'b0;
      strobe_q     <= 1'b0;
    end else begin
      level_a_p1_q <= level_a_p1_d;
      level_b_p1_q <= level_b_p1_d;
      level_c_p1_q <= level_c_p1_d;
      sum_p2_q     <= sum_p2_d;
      cnt_q        <= cnt_d;
      sample_q     <= sample_d;
      pwm_q        <= pwm_d;
      strobe_q     <= strobe_d;
    end
  end

  assign pwm_out       = pwm_q;
  assign sample_strobe = strobe_q;

endmodule
